// File: rtl/matrix_result_streamer.sv
// Captures the systolic array's result matrix on a rising edge of done and streams it
// row-major over valid/ready. Define MRS_SATURATE_EN to clamp elements to [0,255].
module matrix_result_streamer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SIZE  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done,
  input  logic signed [WIDTH-1:0]    A_result [SIZE][SIZE],
  output logic signed [WIDTH-1:0]    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(SIZE)-1:0]    out_row,
  output logic [$clog2(SIZE)-1:0]    out_col,
  output logic                       out_last,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun_err
);

  localparam int unsigned IDX_W = $clog2(SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                    state, state_n;
  logic                      done_q;
  logic                      done_rise;
  logic                      load;
  logic signed [WIDTH-1:0]   frame_buf [SIZE][SIZE];
  logic [IDX_W-1:0]          row_n, col_n;
  logic                      last_n, frame_done_n, overrun_n, valid_n;
  logic signed [WIDTH-1:0]   data_n;

  // Output formatting, applied as each element is selected so it adds no latency
  function automatic logic signed [WIDTH-1:0] fmt(input logic signed [WIDTH-1:0] v);
`ifdef MRS_SATURATE_EN
    logic signed [WIDTH-1:0] pix_max;
    pix_max = WIDTH'(255);
    if (v[WIDTH-1])
      return '0;
    else if (v > pix_max)
      return pix_max;
    else
      return v;
`else
    return v;
`endif
  endfunction

  assign done_rise = done & ~done_q;

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    row_n        = out_row;
    col_n        = out_col;
    last_n       = out_last;
    data_n       = out_data;
    frame_done_n = 1'b0;
    overrun_n    = overrun_err;
    load         = 1'b0;
    case (state)
      IDLE: begin
        if (done_rise) begin
          load    = 1'b1;
          state_n = STREAM;
          row_n   = '0;
          col_n   = '0;
          data_n  = fmt(A_result[0][0]);
          last_n  = (SIZE == 1);
        end
      end
      STREAM: begin
        // A new frame while streaming is dropped; only the error is recorded
        if (done_rise) overrun_n = 1'b1;
        if (out_ready) begin
          if (out_last) begin
            state_n      = IDLE;
            frame_done_n = 1'b1;
            row_n        = '0;
            col_n        = '0;
            last_n       = 1'b0;
            data_n       = '0;
          end else begin
            if (out_col == LAST_IDX) begin
              col_n = '0;
              row_n = out_row + IDX_W'(1);
            end else begin
              col_n = out_col + IDX_W'(1);
            end
            data_n = fmt(frame_buf[row_n][col_n]);
            last_n = (row_n == LAST_IDX) && (col_n == LAST_IDX);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    valid_n = (state_n == STREAM);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      out_row     <= '0;
      out_col     <= '0;
      out_last    <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_n;
      done_q      <= done;
      out_row     <= row_n;
      out_col     <= col_n;
      out_last    <= last_n;
      out_data    <= data_n;
      out_valid   <= valid_n;
      busy        <= valid_n;
      frame_done  <= frame_done_n;
      overrun_err <= overrun_n;
    end
  end

  // Frame capture; contents are don't-care until the next load
  always_ff @(posedge clk) begin
    if (load) frame_buf <= A_result;
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Scoreboard bench for matrix_result_streamer: driver queues expected beats, a negedge
// monitor pops and compares every accepted beat and checks stall stability.
module tb_matrix_result_streamer;

  localparam int W = 16;
  localparam int N = 10;

  typedef struct packed {
    logic signed [W-1:0] data;
    logic [3:0]          row;
    logic [3:0]          col;
    logic                last;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                done;
  logic signed [W-1:0] A_result [N][N];
  logic signed [W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          out_row;
  logic [3:0]          out_col;
  logic                out_last;
  logic                busy;
  logic                frame_done;
  logic                overrun_err;

  matrix_result_streamer #(.WIDTH(W), .SIZE(N)) dut (
    .clk(clk), .rst(rst), .done(done), .A_result(A_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    passed = 0;
  int    exp_cycles = 100;
  beat_t q[$];
  logic signed [W-1:0] m1 [N][N];
  logic signed [W-1:0] m2 [N][N];

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  function automatic logic signed [W-1:0] exp_fmt(input logic signed [W-1:0] v);
`ifdef MRS_SATURATE_EN
    if (v < 0) return 16'sd0;
    if (v > 16'sd255) return 16'sd255;
    return v;
`else
    return v;
`endif
  endfunction

  // Present a matrix, raise done and queue its 100 expected beats
  task automatic start_frame(input bit second);
    beat_t b;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        A_result[r][c] = second ? m2[r][c] : m1[r][c];
        b.data = exp_fmt(A_result[r][c]);
        b.row  = 4'(r);
        b.col  = 4'(c);
        b.last = (r == N-1) && (c == N-1);
        q.push_back(b);
      end
    done = 1'b1;
  endtask

  // Drive out_ready until frame_done; optional overrun pulse or early stop
  task automatic stream_frame(input bit bp, input int ovr_at, input int stop_at);
    logic [3:0] pat;
    bit seen;
    pat  = 4'b1001;
    seen = 1'b0;
    @(posedge clk); #1;
    done = 1'b0;
    check("first_valid", int'(out_valid), 1);
    check("first_busy", int'(busy), 1);
    for (int i = 0; i < 400; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (frame_done) begin
          seen = 1'b1;
          break;
        end
      end
      if (i == stop_at) begin
        out_ready = 1'b1;
        return;
      end
      if (ovr_at >= 0 && i == ovr_at) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) A_result[r][c] = m2[r][c];
        done = 1'b1;
      end
      if (ovr_at >= 0 && i == ovr_at + 1) begin
        done = 1'b0;
        check("overrun_set", int'(overrun_err), 1);
      end
      out_ready = bp ? pat[i[1:0]] : 1'b1;
    end
    if (!seen) check("frame_timeout", 0, 1);
  endtask

  // Monitor: compare accepted beats, stall stability, frame length and frame_done pulse
  beat_t snap;
  bit    stall_v = 1'b0;
  bit    fd_pending = 1'b0;
  int    vcnt = 0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      vcnt = 0;
      stall_v = 1'b0;
      fd_pending = 1'b0;
    end else begin
      if (fd_pending) begin
        check("frame_done_pulse", int'(frame_done), 1);
        check("valid_after_last", int'(out_valid), 0);
        check("busy_after_last", int'(busy), 0);
        fd_pending = 1'b0;
      end else begin
        check("frame_done_idle", int'(frame_done), 0);
      end
      if (stall_v) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(snap.data));
        check("stall_row", int'(out_row), int'(snap.row));
        check("stall_col", int'(out_col), int'(snap.col));
        check("stall_last", int'(out_last), int'(snap.last));
      end
      stall_v = 1'b0;
      if (out_valid) begin
        vcnt++;
        if (q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else if (out_ready) begin
          e = q.pop_front();
          check("data", int'(out_data), int'(e.data));
          check("row", int'(out_row), int'(e.row));
          check("col", int'(out_col), int'(e.col));
          check("last", int'(out_last), int'(e.last));
          if (out_last) begin
            check("frame_cycles", vcnt, exp_cycles);
            vcnt = 0;
            fd_pending = 1'b1;
          end
        end else begin
          snap = '{data: out_data, row: out_row, col: out_col, last: out_last};
          stall_v = 1'b1;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic signed [W-1:0] row0 [N];
    row0 = '{-16'sd1888, 16'sd132, 16'sd2338, 16'sd5173, 16'sd7482,
             16'sd7482, 16'sd5173, 16'sd2338, 16'sd132, -16'sd1888};
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m1[r][c] = (r == 0) ? row0[c] : 16'(row0[c] + 16'(r * 7));
        m2[r][c] = 16'(50 * r + 3 * c - 100);
      end
    rst = 1'b1;
    done = 1'b0;
    out_ready = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) A_result[r][c] = m1[r][c];
    idle(3);
    rst = 1'b0;
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overrun", int'(overrun_err), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_row", int'(out_row), 0);
    check("rst_col", int'(out_col), 0);
    check("rst_last", int'(out_last), 0);
    idle(2);

    // Basic frame, ready held high
    exp_cycles = 100;
    start_frame(1'b0);
    stream_frame(1'b0, -1, -1);
    idle(3);

    // Backpressure 1,0,0,1
    exp_cycles = 200;
    start_frame(1'b0);
    stream_frame(1'b1, -1, -1);
    idle(3);

    // Back-to-back: second done raised in the frame_done cycle
    exp_cycles = 100;
    start_frame(1'b0);
    stream_frame(1'b0, -1, -1);
    start_frame(1'b1);
    stream_frame(1'b0, -1, -1);
    check("b2b_overrun", int'(overrun_err), 0);
    idle(3);

    // Overrun at beat 50: original matrix continues, new frame dropped
    start_frame(1'b0);
    stream_frame(1'b0, 50, -1);
    idle(5);
    check("overrun_sticky", int'(overrun_err), 1);
    check("overrun_no_second", int'(out_valid), 0);
    check("overrun_queue_empty", q.size(), 0);

    // Reset at beat 37 with done held high across reset release
    start_frame(1'b0);
    stream_frame(1'b0, -1, 37);
    rst = 1'b1;
    q.delete();
    start_frame(1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_row", int'(out_row), 0);
    check("midrst_col", int'(out_col), 0);
    check("midrst_overrun", int'(overrun_err), 0);
    stream_frame(1'b0, -1, -1);
    idle(3);
    check("final_queue_empty", q.size(), 0);
    check("final_valid", int'(out_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
